// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, register geometry and FSM state types
// used by the register-bank slave and its per-register storage cells.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int REG_W  = 32;
    localparam int STRB_W = REG_W / 8;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi4_lite_strb_reg.sv
// One 32-bit control register with per-byte write strobes; one instance per register
// of the AXI4-Lite register bank.
module axi4_lite_strb_reg
    import axi4_lite_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_W-1:0]  wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    output logic [REG_W-1:0]  data_o
);

    logic [REG_W-1:0] data_q;
    logic [REG_W-1:0] data_d;

    always_comb begin
        // NOTE: hold value assigned first so every path drives data_d and no latch is inferred.
        data_d = data_q;
        if (we_i) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wstrb_i[k]) begin
                    data_d[8*k +: 8] = wdata_i[8*k +: 8];
                end
            end
        end
    end

    // NOTE: this is a software-visible register file, not a RAM, so every cell is reset to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            // NOTE: non-blocking so all registers sample pre-edge values on the same edge.
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing G_NB_REGS byte-strobed 32-bit registers, with independent
// write (AW/W/B) and read (AR/R) state machines and a per-register write strobe.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 8,
    parameter int G_DATA_WIDTH = 32,
    parameter int G_NB_REGS    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [G_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [G_DATA_WIDTH-1:0]   s_wdata,
    input  logic [G_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [G_ADDR_WIDTH-1:0]   s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [G_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [G_NB_REGS*32-1:0]   regs_o,
    output logic [G_NB_REGS-1:0]      wr_pulse_o
);

    localparam int          IDX_W     = G_ADDR_WIDTH - 2;
    localparam logic [31:0] NB_REGS_U = 32'(G_NB_REGS);

    wr_state_e                wr_state_q, wr_state_d;
    logic                     aw_done_q, aw_done_d;
    logic [IDX_W-1:0]         aw_idx_q, aw_idx_d;
    logic                     w_done_q, w_done_d;
    logic [REG_W-1:0]         wdata_q, wdata_d;
    logic [STRB_W-1:0]        wstrb_q, wstrb_d;
    logic                     awready_q, awready_d;
    logic                     wready_q, wready_d;
    logic                     bvalid_q, bvalid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic [G_NB_REGS-1:0]     wr_pulse_q, wr_pulse_d;

    rd_state_e                rd_state_q, rd_state_d;
    logic                     arready_q, arready_d;
    logic                     rvalid_q, rvalid_d;
    logic [REG_W-1:0]         rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;

    logic                     aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]         wr_idx;
    logic [31:0]              wr_idx32, ar_idx32;
    logic                     wr_in_range, ar_in_range;
    logic [REG_W-1:0]         wr_data, rd_val;
    logic [STRB_W-1:0]        wr_strb;
    logic [G_NB_REGS-1:0]     wr_en;
    logic [REG_W-1:0]         reg_val [G_NB_REGS];
    logic                     unused_lsbs;

    assign unused_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign aw_hs = s_awvalid & awready_q;
    assign w_hs  = s_wvalid & wready_q;
    assign ar_hs = s_arvalid & arready_q;

    // A channel already latched takes precedence; otherwise the beat handshaking now is used.
    assign wr_idx      = aw_done_q ? aw_idx_q : s_awaddr[G_ADDR_WIDTH-1:2];
    assign wr_data     = w_done_q ? wdata_q : s_wdata;
    assign wr_strb     = w_done_q ? wstrb_q : s_wstrb;
    assign wr_idx32    = 32'(wr_idx);
    assign wr_in_range = wr_idx32 < NB_REGS_U;
    assign commit      = (wr_state_q == W_IDLE) && (aw_done_q | aw_hs) && (w_done_q | w_hs);

    assign ar_idx32    = 32'(s_araddr[G_ADDR_WIDTH-1:2]);
    assign ar_in_range = ar_idx32 < NB_REGS_U;

    for (genvar g = 0; g < G_NB_REGS; g++) begin : g_reg
        assign wr_en[g] = commit && wr_in_range && (wr_idx32 == 32'(g));

        axi4_lite_strb_reg u_reg (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (wr_en[g]),
            .wdata_i (wr_data),
            .wstrb_i (wr_strb),
            .data_o  (reg_val[g])
        );

        assign regs_o[32*g +: 32] = reg_val[g];
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_done_d  = aw_done_q;
        aw_idx_d   = aw_idx_q;
        w_done_d   = w_done_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    aw_idx_d  = s_awaddr[G_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                end
                if (commit) begin
                    wr_state_d = W_RESP;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    wr_state_d = W_IDLE;
                    bvalid_d   = 1'b0;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        // Readies are registered, so they are derived from the next-cycle state.
        awready_d  = (wr_state_d == W_IDLE) && !aw_done_d;
        wready_d   = (wr_state_d == W_IDLE) && !w_done_d;
        wr_pulse_d = wr_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            aw_done_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_done_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_done_q  <= aw_done_d;
            aw_idx_q   <= aw_idx_d;
            w_done_q   <= w_done_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Out-of-range indices match no register and therefore read as 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < G_NB_REGS; i++) begin
            if (ar_idx32 == 32'(i)) begin
                rd_val = reg_val[i];
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_val;
                    rresp_d    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_awready  = awready_q;
    assign s_wready   = wready_q;
    assign s_bvalid   = bvalid_q;
    assign s_bresp    = bresp_q;
    assign s_arready  = arready_q;
    assign s_rvalid   = rvalid_q;
    assign s_rdata    = rdata_q;
    assign s_rresp    = rresp_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed scenarios plus randomized
// AXI4-Lite traffic compared against an array-based register model.
module tb_axi4_lite_slave_regs;

    localparam int NB      = 16;
    localparam int TIMEOUT = 50;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        s_awaddr = '0;
    logic              s_awvalid = 1'b0;
    logic              s_awready;
    logic [31:0]       s_wdata = '0;
    logic [3:0]        s_wstrb = '0;
    logic              s_wvalid = 1'b0;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready = 1'b0;
    logic [7:0]        s_araddr = '0;
    logic              s_arvalid = 1'b0;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready = 1'b0;
    logic [NB*32-1:0]  regs_o;
    logic [NB-1:0]     wr_pulse_o;

    logic [31:0] model_regs [NB];
    int          exp_pulse  [NB];
    int          pulse_cnt  [NB];
    int          tests_run    = 0;
    int          tests_failed = 0;

    axi4_lite_slave_regs #(
        .G_ADDR_WIDTH (8),
        .G_DATA_WIDTH (32),
        .G_NB_REGS    (NB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_awaddr   (s_awaddr),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_bresp    (s_bresp),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 clk = ~clk;

    // Counts strobe-high cycles per register; each commit must add exactly one.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_pulse_o[i]) pulse_cnt[i]++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // ---- reference model ----
    function automatic logic [1:0] model_resp(input logic [7:0] addr);
        return (int'(addr[7:2]) < NB) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        int idx = int'(addr[7:2]);
        return (idx < NB) ? model_regs[idx] : 32'h0;
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx = int'(addr[7:2]);
        if (idx < NB) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model_regs[idx][8*k +: 8] = data[8*k +: 8];
            end
            exp_pulse[idx]++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) model_regs[i] = '0;
    endtask

    function automatic logic [7:0] rand_addr();
        logic [7:0] a;
        a = 8'($urandom);
        if ($urandom_range(0, 7) != 0) a[7:6] = 2'b00;
        else if (a[7:6] == 2'b00) a[6] = 1'b1;
        return a;
    endfunction

    task automatic check_state(input string tag);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s_reg%0d", tag, i), regs_o[32*i +: 32], model_regs[i]);
            check($sformatf("%s_pulse%0d", tag, i), pulse_cnt[i], exp_pulse[i]);
        end
        check($sformatf("%s_pulse_idle", tag), 32'(wr_pulse_o), 32'h0);
    endtask

    // ---- bus drivers (called and returning on a falling edge) ----
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] exp_resp);
        int n;
        fork
            begin
                int m = 0;
                repeat (aw_dly) @(negedge clk);
                s_awaddr  = addr;
                s_awvalid = 1'b1;
                while (!s_awready && m < TIMEOUT) begin
                    @(negedge clk);
                    m++;
                end
                check("aw_wait", 32'(m < TIMEOUT), 32'h1);
                @(negedge clk);
                s_awvalid = 1'b0;
                s_awaddr  = 8'($urandom);
            end
            begin
                int m = 0;
                repeat (w_dly) @(negedge clk);
                s_wdata  = data;
                s_wstrb  = strb;
                s_wvalid = 1'b1;
                while (!s_wready && m < TIMEOUT) begin
                    @(negedge clk);
                    m++;
                end
                check("w_wait", 32'(m < TIMEOUT), 32'h1);
                @(negedge clk);
                s_wvalid = 1'b0;
                s_wdata  = $urandom;
                s_wstrb  = 4'($urandom);
            end
        join
        check("bvalid_latency", 32'(s_bvalid), 32'h1);
        check("bresp", 32'(s_bresp), 32'(exp_resp));
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(s_bvalid), 32'h1);
            check("bresp_hold", 32'(s_bresp), 32'(exp_resp));
            check("awready_busy", 32'({s_awready, s_wready}), 32'h0);
        end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        check("bvalid_clear", 32'(s_bvalid), 32'h0);
        check("wr_readies_back", 32'({s_awready, s_wready}), 32'h3);
        n = 0;
    endtask

    task automatic do_read(input logic [7:0] addr, input int ar_dly, input int r_dly,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int m = 0;
        repeat (ar_dly) @(negedge clk);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        while (!s_arready && m < TIMEOUT) begin
            @(negedge clk);
            m++;
        end
        check("ar_wait", 32'(m < TIMEOUT), 32'h1);
        @(negedge clk);
        s_arvalid = 1'b0;
        s_araddr  = 8'($urandom);
        check("rvalid_latency", 32'(s_rvalid), 32'h1);
        check("rdata", s_rdata, exp_data);
        check("rresp", 32'(s_rresp), 32'(exp_resp));
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("rvalid_hold", 32'(s_rvalid), 32'h1);
            check("rdata_hold", s_rdata, exp_data);
            check("arready_busy", 32'(s_arready), 32'h0);
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        check("rvalid_clear", 32'(s_rvalid), 32'h0);
        check("arready_back", 32'(s_arready), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  wa, ra;
        logic [31:0] wd, exp_rd;
        logic [3:0]  ws;
        int          op;

        for (int i = 0; i < NB; i++) begin
            model_regs[i] = '0;
            exp_pulse[i]  = 0;
            pulse_cnt[i]  = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_readies", 32'({s_awready, s_wready, s_arready}), 32'h0);
        check("rst_valids", 32'({s_bvalid, s_rvalid}), 32'h0);
        check("rst_resps", 32'({s_bresp, s_rresp}), 32'h0);
        check("rst_rdata", s_rdata, 32'h0);
        check_state("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_readies", 32'({s_awready, s_wready, s_arready}), 32'h7);

        // Same-cycle AW/W write to register 1
        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00);
        model_write(8'h04, 32'hDEADBEEF, 4'hF);
        check("t26_reg1", regs_o[63:32], 32'hDEADBEEF);
        check_state("t26");

        // W leads AW by three cycles; commit only on the AW edge
        do_write(8'h08, 32'hAAAAAAAA, 4'hF, 0, 0, 0, 2'b00);
        model_write(8'h08, 32'hAAAAAAAA, 4'hF);
        fork
            do_write(8'h08, 32'h11223344, 4'h5, 3, 0, 0, 2'b00);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t27_reg2_hold", regs_o[95:64], 32'hAAAAAAAA);
                    check("t27_no_bvalid", 32'(s_bvalid), 32'h0);
                end
            end
        join
        model_write(8'h08, 32'h11223344, 4'h5);
        check("t27_reg2", regs_o[95:64], 32'hAA22AA44);
        check_state("t27");

        // Read with rready held low for four cycles
        do_read(8'h04, 0, 4, 32'hDEADBEEF, 2'b00);

        // Out-of-range write and read
        do_write(8'h40, $urandom, 4'hF, 0, 1, 1, 2'b10);
        model_write(8'h40, 32'h0, 4'hF);
        check_state("t29");
        do_read(8'h40, 0, 1, 32'h0, 2'b10);

        // Read captured on the same edge as a write commit returns the old value
        wd = $urandom;
        do_write(8'h0C, wd, 4'hF, 0, 0, 0, 2'b00);
        model_write(8'h0C, wd, 4'hF);
        exp_rd = model_read(8'h0C);
        fork
            do_write(8'h0C, 32'h12345678, 4'hF, 0, 0, 0, 2'b00);
            do_read(8'h0C, 0, 0, exp_rd, 2'b00);
        join
        model_write(8'h0C, 32'h12345678, 4'hF);
        check_state("t31");
        do_read(8'h0C, 0, 0, 32'h12345678, 2'b00);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 2);
            wa = rand_addr();
            ra = rand_addr();
            wd = $urandom;
            ws = 4'($urandom);
            if (op == 0) begin
                do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), model_resp(wa));
                model_write(wa, wd, ws);
                check_state("rnd_w");
            end else if (op == 1) begin
                do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), model_read(ra), model_resp(ra));
            end else begin
                if (ra[7:2] == wa[7:2]) ra[2] = ~ra[2];
                exp_rd = model_read(ra);
                fork
                    do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), model_resp(wa));
                    do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), exp_rd, model_resp(ra));
                join
                model_write(wa, wd, ws);
                check_state("rnd_wr");
            end
        end

        // Reset while parked in W_RESP and R_DATA
        wd = $urandom;
        s_awaddr  = 8'h14;
        s_awvalid = 1'b1;
        s_wdata   = wd;
        s_wstrb   = 4'hF;
        s_wvalid  = 1'b1;
        s_araddr  = 8'h04;
        s_arvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        model_write(8'h14, wd, 4'hF);
        check("t30_busy_valids", 32'({s_bvalid, s_rvalid}), 32'h3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t30_valids", 32'({s_bvalid, s_rvalid}), 32'h0);
        check("t30_readies_low", 32'({s_awready, s_wready, s_arready}), 32'h0);
        check("t30_rdata", s_rdata, 32'h0);
        check_state("t30");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t30_readies", 32'({s_awready, s_wready, s_arready}), 32'h7);

        // Bank usable again after reset
        do_write(8'h3C, 32'hCAFEF00D, 4'hC, 1, 0, 0, 2'b00);
        model_write(8'h3C, 32'hCAFEF00D, 4'hC);
        check_state("post_rst");
        do_read(8'h3C, 0, 0, 32'hCAFE0000, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 SHALL have parameter G_ADDR_WIDTH, default 8, byte-address width.
REQ-002 SHALL have parameter G_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter G_NB_REGS, default 16, number of 32-bit registers, 1..2**(G_ADDR_WIDTH-2).
REQ-004 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports s_awaddr (in, G_ADDR_WIDTH), s_awvalid (in, 1) and s_awready (out, 1), forming the write-address channel.
REQ-007 SHALL have ports s_wdata (in, 32), s_wstrb (in, 4), s_wvalid (in, 1) and s_wready (out, 1), forming the write-data channel.
REQ-008 SHALL have ports s_bresp (out, 2), s_bvalid (out, 1) and s_bready (in, 1), forming the write-response channel.
REQ-009 SHALL have ports s_araddr (in, G_ADDR_WIDTH), s_arvalid (in, 1) and s_arready (out, 1), forming the read-address channel.
REQ-010 SHALL have ports s_rdata (out, 32), s_rresp (out, 2), s_rvalid (out, 1) and s_rready (in, 1), forming the read-data channel.
REQ-011 SHALL have port regs_o, output, G_NB_REGS*32, giving the register contents; register i occupies bits [32*i+31:32*i].
REQ-012 SHALL have port wr_pulse_o, output, G_NB_REGS, a one-cycle strobe per register on each committed write.

Function
REQ-013 Register index SHALL be addr[G_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
REQ-014 An index >= G_NB_REGS SHALL give resp 2'b10 (SLVERR); no register changes and rdata is 0. An in-range index SHALL give resp 2'b00 (OKAY).
REQ-015 The write FSM SHALL have states W_IDLE, W_RESP.
- In W_IDLE, AW and W handshakes are accepted independently, in any order or in the same cycle.
- Each accepted address or data is latched.
- s_awready is deasserted once AW is latched; s_wready is deasserted once W is latched.
REQ-016 The write SHALL commit on the edge that completes the second of the two handshakes.
- Byte lane k is updated only where s_wstrb[k]=1.
- wr_pulse_o[index] is 1 for exactly the following cycle; wstrb=0 in range still pulses.
- FSM moves to W_RESP; s_bvalid is 1 from the next cycle.
REQ-017 In W_RESP, s_awready=s_wready=0 and s_bvalid/s_bresp SHALL be held stable until s_bready=1. On the s_bready edge the FSM SHALL return to W_IDLE with both ready signals high the next cycle.
REQ-018 The read FSM SHALL have states R_IDLE (s_arready=1) and R_DATA (s_arready=0, s_rvalid=1).
- On the AR handshake edge, s_rdata/s_rresp are registered from current contents and the FSM enters R_DATA.
- Read latency is 1 cycle.
REQ-019 In R_DATA, s_rdata/s_rresp SHALL be held stable until s_rready=1, then the FSM SHALL return to R_IDLE.
REQ-020 Read and write paths SHALL be independent and operate concurrently. A read of a register captured on the same edge as a write commit to it SHALL return the pre-write value.
REQ-021 Input values while valid=0 SHALL have no effect.

Reset
REQ-022 On rst_n=0, asynchronously and regardless of any transaction in progress:
- all registers and regs_o are 0; wr_pulse_o is 0;
- s_bvalid=s_rvalid=0, s_bresp=s_rresp=0, s_rdata=0;
- both FSMs are in IDLE with latches cleared.
REQ-023 s_awready, s_wready and s_arready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.

Structure
REQ-024 A shared package axi4_lite_pkg SHALL hold the resp constants (OKAY=2'b00, SLVERR=2'b10) and the write/read FSM state enums.
REQ-025 The byte-strobe register update SHALL be one sub-module, axi4_lite_strb_reg, one instance per register.

Verification
REQ-026 AW 0x04 and W 0xDEADBEEF/strb 0xF in the same cycle, bready=1 -> bvalid one cycle after the handshake, bresp=00, regs_o[63:32]=0xDEADBEEF, wr_pulse_o[1] for one cycle.
REQ-027 W (0x11223344, strb 0x5) three cycles before AW 0x08, register holding 0xAAAAAAAA -> commit only at the AW edge, value 0xAA22AA44.
REQ-028 AR 0x04 with rready=0 for 4 cycles -> rvalid and rdata=0xDEADBEEF held stable, then released on rready.
REQ-029 Write and read to 0x40 with G_NB_REGS=16 -> bresp=10, rresp=10, rdata=0, no regs_o change, no wr_pulse_o.
REQ-030 rst_n asserted while in W_RESP and R_DATA -> bvalid=rvalid=0 immediately, regs_o=0, all readies 1 one cycle after release.
REQ-031 Read of 0x0C on the same edge as a write 0x12345678 to 0x0C -> rdata=old value; a subsequent read returns 0x12345678.
